// File: rtl/dma_copy.sv
// Memory-to-memory copy engine: alternates bus reads and writes, using halfword
// transfers while at least two bytes remain (when enabled), byte transfers otherwise.
//
// state | meaning
// IDLE  | waiting for start; latches src/dst/len
// RD    | read request at src_cur outstanding
// WR    | write request of captured data at dst_cur outstanding
// DONE  | one-cycle completion pulse
module dma_copy #(
  parameter int HALFWORD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] src,
  input  logic [15:0] dst,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] addr,
  output logic [15:0] wdata,
  output logic [1:0]  wstrb,
  input  logic [15:0] rdata,
  input  logic        ready
);

  localparam bit HW = (HALFWORD_EN != 0);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] src_cur, dst_cur, rem, data_buf;
  logic [15:0] src_n, dst_n, rem_n, buf_n;
  logic [15:0] step_cur, step_n, rem_dec;
  logic        valid_n, busy_n, done_n;
  logic [15:0] addr_n, wdata_n;
  logic [1:0]  wstrb_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      src_cur  <= '0;
      dst_cur  <= '0;
      rem      <= '0;
      data_buf <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= 2'b00;
    end else begin
      state    <= state_n;
      src_cur  <= src_n;
      dst_cur  <= dst_n;
      rem      <= rem_n;
      data_buf <= buf_n;
      valid    <= valid_n;
      busy     <= busy_n;
      done     <= done_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      wstrb    <= wstrb_n;
    end
  end

  always_comb begin
    state_n  = state;
    src_n    = src_cur;
    dst_n    = dst_cur;
    rem_n    = rem;
    buf_n    = data_buf;
    step_cur = (HW && rem >= 16'd2) ? 16'd2 : 16'd1;
    rem_dec  = rem - step_cur;

    case (state)
      IDLE: begin
        if (start) begin
          src_n   = src;
          dst_n   = dst;
          rem_n   = len;
          state_n = (len == 16'd0) ? DONE : RD;
        end
      end
      RD: begin
        if (ready) begin
          buf_n   = (step_cur == 16'd2) ? rdata : {8'h00, rdata[7:0]};
          state_n = WR;
        end
      end
      WR: begin
        if (ready) begin
          src_n   = src_cur + step_cur;
          dst_n   = dst_cur + step_cur;
          rem_n   = rem_dec;
          state_n = (rem_dec == 16'd0) ? DONE : RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state.
    step_n  = (HW && rem_n >= 16'd2) ? 16'd2 : 16'd1;
    valid_n = (state_n == RD) || (state_n == WR);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    addr_n  = addr;
    wdata_n = wdata;
    wstrb_n = 2'b00;
    if (state_n == RD) begin
      addr_n = src_n;
    end else if (state_n == WR) begin
      addr_n  = dst_n;
      wdata_n = buf_n;
      wstrb_n = (step_n == 16'd2) ? 2'b11 : 2'b01;
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: byte-array responder with programmable wait states, and a
// chunk-by-chunk reference copy model that predicts every bus request and the final image.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done, valid;
  logic [15:0] addr, wdata;
  logic [1:0]  wstrb;
  logic [15:0] rdata = '0;
  logic        ready = 1'b0;

  dma_copy #(.HALFWORD_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .valid(valid), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  strb;
    logic [15:0] data;
  } req_t;

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  logic [7:0] pre_mem [65536];
  req_t       exp_q[$];
  int         n_wait = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: copy proceeds in chunks of 2 bytes while >=2 remain, else 1 byte.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    logic [15:0] a_s, a_d, r, s1, d1, data;
    req_t        q;
    a_s = s; a_d = d; r = l;
    while (r != 16'd0) begin
      s1 = a_s + 16'd1;
      d1 = a_d + 16'd1;
      q.addr = a_s; q.strb = 2'b00; q.data = 16'h0000;
      exp_q.push_back(q);
      if (r >= 16'd2) begin
        data = {ref_mem[s1], ref_mem[a_s]};
        ref_mem[a_d] = data[7:0];
        ref_mem[d1]  = data[15:8];
        q.addr = a_d; q.strb = 2'b11; q.data = data;
        exp_q.push_back(q);
        a_s += 16'd2; a_d += 16'd2; r -= 16'd2;
      end else begin
        data = {8'h00, ref_mem[a_s]};
        ref_mem[a_d] = data[7:0];
        q.addr = a_d; q.strb = 2'b01; q.data = data;
        exp_q.push_back(q);
        a_s += 16'd1; a_d += 16'd1; r -= 16'd1;
      end
    end
  endtask

  // Responder: checks each request against the model on every cycle it is held.
  initial begin : responder
    req_t        cur;
    bit          in_req, stray;
    int          wcnt;
    logic [15:0] a1;
    in_req = 0; stray = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (ready) begin
        ready  = 1'b0;
        in_req = 0;
      end
      rdata = 16'($urandom);
      if (rst) begin
        in_req = 0;
        wcnt   = 0;
      end else if (valid) begin
        if (!in_req) begin
          in_req = 1;
          wcnt   = 0;
          stray  = (exp_q.size() == 0);
          if (stray) chk("extra_req", 1, 0);
          else begin
            cur = exp_q.pop_front();
            chk("req_addr", addr, cur.addr);
            chk("req_strb", wstrb, cur.strb);
            if (cur.strb != 2'b00) chk("req_wdata", wdata, cur.data);
          end
        end else if (!stray) begin
          chk("hold_addr", addr, cur.addr);
          chk("hold_strb", wstrb, cur.strb);
          if (cur.strb != 2'b00) chk("hold_wdata", wdata, cur.data);
        end
        if (wcnt >= n_wait) begin
          ready = 1'b1;
          a1    = addr + 16'd1;
          if (wstrb == 2'b00) rdata = {mem[a1], mem[addr]};
          else begin
            mem[addr] = wdata[7:0];
            if (wstrb == 2'b11) mem[a1] = wdata[15:8];
          end
        end else wcnt++;
      end
    end
  end

  task automatic check_image();
    int bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
  endtask

  // Call just after a negedge; returns at the negedge where busy has dropped.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int w, input bit mid);
    int busy_cnt = 0, done_cnt = 0, vseen = 0;
    bit fin = 0;
    n_wait = w;
    model_copy(s, d, l);
    src = s; dst = d; len = l; start = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mid && c == 3) begin
        start = 1'b1; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
      end
      if (busy) busy_cnt++;
      if (valid) vseen++;
      if (done) begin
        done_cnt++;
        chk("done_valid", valid, 0);
      end
      if (!busy && busy_cnt > 0) fin = 1;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("done_pulses", done_cnt, 1);
    if (l == 16'd0) begin
      chk("zero_busy", busy_cnt, 1);
      chk("zero_valid", vseen, 0);
    end
    chk("req_left", 32'(exp_q.size()), 0);
    check_image();
  endtask

  initial begin : main
    bit found;
    int vbad;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_copy(16'h0010, 16'h0100, 16'd4, 0, 0);
    run_copy(16'h0021, 16'h0040, 16'd3, 0, 0);
    run_copy(16'h0030, 16'h0050, 16'd0, 0, 0);
    run_copy(16'h0200, 16'h0300, 16'd5, 3, 0);
    run_copy(16'hFFFE, 16'h1000, 16'd4, 1, 1);

    // Abort during the second halfword write; only the first write is committed.
    for (int i = 0; i < 65536; i++) pre_mem[i] = ref_mem[i];
    model_copy(16'h0400, 16'h0500, 16'd4);
    for (int i = 0; i < 65536; i++) ref_mem[i] = pre_mem[i];
    ref_mem[16'h0500] = pre_mem[16'h0400];
    ref_mem[16'h0501] = pre_mem[16'h0401];
    n_wait = 3;
    src = 16'h0400; dst = 16'h0500; len = 16'd4; start = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      if (valid && wstrb == 2'b11 && addr == 16'h0502 && !ready) found = 1;
    end
    chk("abort_reached", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wstrb", wstrb, 0);
    chk("abort_addr", addr, 0);
    vbad = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) vbad++;
    end
    chk("abort_quiet", vbad, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_copy(16'h0600, 16'h0700, 16'd2, 0, 0);

    for (int k = 0; k < 20; k++)
      run_copy(16'($urandom), 16'($urandom), 16'($urandom_range(0, 9)),
               int'($urandom_range(0, 3)), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
